key_schedule_ctrl: RTL and testbench

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

---
 rtl/present_pkg.sv | 24 ++
 rtl/key_update.sv | 21 ++
 rtl/key_schedule_ctrl.sv | 91 +++++++++
 tb/tb_key_schedule_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared constants, state encoding and PRESENT S-box for the round-key scheduler.
// Pure declarations: no latency and no flow control of its own.
// The key_update datapath and key_schedule_ctrl both import this package.
package present_pkg;

    localparam int KEY_W = 20;
    localparam int RK_W  = 16;
    localparam int CNT_W = 4;
    localparam int ROT_L = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } ks_state_e;

    // Entry i lives in nibble i: S(0)=C, S(1)=5, ... S(15)=2.
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/key_update.sv
// Next-key function: rotate left by 13, S-box on the top nibble, XOR counter into bits [7:4].
// Purely combinational, zero cycles.
// No handshake; the caller decides when the result is loaded.
module key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key_cur,
    input  logic [CNT_W-1:0] cnt,
    output logic [KEY_W-1:0] key_nxt
);

    logic [KEY_W-1:0] key_rot;

    always_comb begin
        key_rot        = {key_cur[KEY_W-ROT_L-1:0], key_cur[KEY_W-1:KEY_W-ROT_L]};
        key_nxt        = key_rot;
        key_nxt[19:16] = sbox_lookup(key_rot[19:16]);
        key_nxt[7:4]   = key_rot[7:4] ^ cnt;
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Issues NUM_RK round keys from a captured master key, one per valid/ready transfer.
// First key one cycle after start; one key per cycle while rk_ready stays high.
// rk_ready low holds round_key/rk_index; abort drops the schedule and scrubs the key.
module key_schedule_ctrl
    import present_pkg::*;
#(
    parameter int NUM_RK = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              abort,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [RK_W-1:0]   round_key,
    output logic [CNT_W-1:0]  rk_index,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_RK - 1);

    ks_state_e        state, state_nxt;
    logic [KEY_W-1:0] key_reg, key_reg_nxt;
    logic [KEY_W-1:0] key_upd;
    logic [CNT_W-1:0] idx_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = rk_index + CNT_W'(1);

    key_update u_key_update (
        .key_cur (key_reg),
        .cnt     (cnt_nxt),
        .key_nxt (key_upd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            key_reg  <= '0;
            rk_index <= '0;
        end else begin
            state    <= state_nxt;
            key_reg  <= key_reg_nxt;
            rk_index <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        key_reg_nxt = key_reg;
        idx_nxt     = rk_index;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    key_reg_nxt = key_in;
                    idx_nxt     = '0;
                    state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Abort wins over a simultaneous transfer so no key is advanced.
                if (abort) begin
                    key_reg_nxt = '0;
                    idx_nxt     = '0;
                    state_nxt   = ST_IDLE;
                end else if (rk_ready) begin
                    if (rk_index == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        key_reg_nxt = key_upd;
                        idx_nxt     = cnt_nxt;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rk_valid  = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign round_key = key_reg[KEY_W-1:KEY_W-RK_W];

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a behavioural schedule model.
// Directed known-answer, backpressure, abort, async-reset cases plus random traffic.
module tb_key_schedule_ctrl;

    localparam int NUM_RK = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] key_in;
    logic        abort;
    logic        rk_valid;
    logic        rk_ready;
    logic [15:0] round_key;
    logic [3:0]  rk_index;
    logic        busy;
    logic        done;

    key_schedule_ctrl #(.NUM_RK(NUM_RK)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .abort     (abort),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_index  (rk_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: issuing flag, done-pulse flag, key value, index.
    int unsigned sbox [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    bit          m_active = 0;
    bit          m_done   = 0;
    int unsigned m_key    = 0;
    int unsigned m_idx    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned next_key(input int unsigned k, input int unsigned c);
        int unsigned r;
        r = ((k << 13) | (k >> 7)) & 32'hFFFFF;
        r = (r & 32'h0FFFF) | (sbox[r >> 16] << 16);
        r = r ^ ((c & 15) << 4);
        return r;
    endfunction

    task automatic model_update();
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 0;
                m_key    = 0;
                m_idx    = 0;
            end else if (rk_ready) begin
                if (m_idx == NUM_RK - 1) begin
                    m_active = 0;
                    m_done   = 1;
                end else begin
                    m_key = next_key(m_key, m_idx + 1);
                    m_idx = m_idx + 1;
                end
            end
        end else if (start) begin
            m_key    = key_in;
            m_idx    = 0;
            m_active = 1;
        end
    endtask

    task automatic compare_all();
        check_eq("rk_valid", rk_valid, m_active);
        check_eq("busy", busy, m_active | m_done);
        check_eq("done", done, m_done);
        check_eq("round_key", round_key, m_key >> 4);
        check_eq("rk_index", rk_index, m_idx);
    endtask

    // Inputs are changed only at the falling edge, so DUT and model see the same values.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic begin_schedule(input logic [19:0] k);
        start  = 1'b1;
        key_in = k;
        step();
        start  = 1'b0;
    endtask

    task automatic run_to_index(input int unsigned n);
        rk_ready = 1'b1;
        for (int c = 0; c < 40 && m_idx != n; c++) step();
        check_eq("reach_index", rk_index, n);
    endtask

    task automatic drain();
        start = 1'b0;
        abort = 1'b0;
        rk_ready = 1'b1;
        for (int c = 0; c < 40 && (m_active || m_done); c++) step();
        check_eq("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int unsigned xfers;
        int unsigned dones;
        logic [15:0] held_key;

        rst = 1'b1; start = 1'b0; key_in = '0; abort = 1'b0; rk_ready = 1'b0;
        #12;
        check_eq("rst_valid", rk_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_key", round_key, 16'h0);
        check_eq("rst_index", rk_index, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // Known answer with zero key, then full 16-key burst at full throughput.
        begin_schedule(20'h00000);
        check_eq("kat_rk0", round_key, 16'h0000);
        check_eq("kat_idx0", rk_index, 4'd0);
        rk_ready = 1'b1;
        xfers = 0;
        dones = 0;
        for (int c = 0; c < 40 && (m_active || m_done); c++) begin
            if (rk_valid && xfers == 1) begin
                check_eq("kat_rk1", round_key, 16'hC001);
                check_eq("kat_idx1", rk_index, 4'd1);
            end
            if (rk_valid && rk_ready) begin
                check_eq("burst_idx", rk_index, xfers);
                xfers++;
            end
            step();
            if (done) dones++;
        end
        check_eq("burst_xfers", xfers, NUM_RK);
        check_eq("burst_dones", dones, 1);
        check_eq("burst_busy", busy, 1'b0);
        step();
        check_eq("post_done", done, 1'b0);

        // Backpressure: hold rk_ready low for 5 cycles at index 3.
        begin_schedule(20'($urandom));
        run_to_index(3);
        held_key = round_key;
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("stall_idx", rk_index, 4'd3);
            check_eq("stall_key", round_key, held_key);
        end
        drain();

        // Abort together with a transfer at index 7.
        begin_schedule(20'($urandom));
        run_to_index(7);
        abort = 1'b1;
        rk_ready = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_key", round_key, 16'h0);
        check_eq("abort_idx", rk_index, 4'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("abort_nodone", done, 1'b0);
        end

        // start with a different key during ISSUE must not disturb the schedule.
        begin_schedule(20'($urandom));
        for (int c = 0; c < 12; c++) begin
            start    = 1'b1;
            key_in   = 20'($urandom);
            rk_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        // Asynchronous reset between clock edges at index 5.
        begin_schedule(20'($urandom));
        run_to_index(5);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", rk_valid, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_key", round_key, 16'h0);
        check_eq("arst_idx", rk_index, 4'd0);
        m_active = 0; m_done = 0; m_key = 0; m_idx = 0;
        @(negedge clk);
        rst = 1'b0;
        begin_schedule(20'($urandom));
        check_eq("fresh_valid", rk_valid, 1'b1);
        drain();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            start    = ($urandom_range(0, 3) == 0);
            key_in   = 20'($urandom);
            abort    = ($urandom_range(0, 19) == 0);
            rk_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
